distance_averager: RTL and testbench

Moving-average filter between the ADC-to-distance conversion and `distance2frequency_converter`. It takes raw distance samples (10^-2 cm) with a valid strobe and keeps a ring buffer of the most recent 2^LOG2_DEPTH samples plus a running sum. It outputs the floor mean as a held, registered `distance`, so the downstream flash-rate logic sees a stable, de-noised value that changes only on accepted samples. An optional spike-reject stage drops isolated outliers.

---
 rtl/distance_averager.sv | 128 ++++++++++++
 tb/tb_distance_averager.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/distance_averager.sv
// distance_averager: floor moving average over the last 2**LOG2_DEPTH distance samples, registered and held.
// Define DISTANCE_SPIKE_REJECT_EN to compile in isolated-outlier rejection (spike output).
module distance_averager #(
    parameter int WIDTH           = 13,
    parameter int LOG2_DEPTH      = 4,
    parameter int SPIKE_THRESHOLD = 500,
    parameter int MAX_REJECTS     = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] distance,
    output logic             distance_valid,
    output logic             primed,
    output logic             spike
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = WIDTH + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FILL_FULL = (LOG2_DEPTH + 1)'(DEPTH);

    logic [WIDTH-1:0]      r_buf [DEPTH];
    logic [SUM_W-1:0]      r_sum;
    logic [LOG2_DEPTH-1:0] r_wrPtr;
    logic [LOG2_DEPTH:0]   r_fillCount;
    logic                  r_primed;
    logic                  r_updatePending;
    logic [WIDTH-1:0]      r_distance;
    logic                  r_distanceValid;

    logic                  w_offered;
    logic                  w_reject;
    logic                  w_accept;
    logic [SUM_W-1:0]      w_sumNext;
    logic [LOG2_DEPTH:0]   w_fillNext;

    assign w_offered  = enable && sample_valid;
    assign w_accept   = w_offered && !w_reject;
    // The evicted entry is always part of r_sum, so the subtraction never wraps.
    assign w_sumNext  = r_sum + SUM_W'(sample) - SUM_W'(r_buf[r_wrPtr]);
    assign w_fillNext = r_fillCount + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_sum       <= '0;
            r_wrPtr     <= '0;
            r_fillCount <= '0;
            r_primed    <= 1'b0;
        end else if (w_accept) begin
            r_buf[r_wrPtr] <= sample;
            r_sum          <= w_sumNext;
            r_wrPtr        <= r_wrPtr + 1'b1;
            if (r_fillCount != FILL_FULL) begin
                r_fillCount <= w_fillNext;
                if (w_fillNext == FILL_FULL) begin
                    r_primed <= 1'b1;
                end
            end
        end
    end

    // Second stage: publish the mean one edge after the sum moves; valid only once primed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_updatePending <= 1'b0;
            r_distance      <= '0;
            r_distanceValid <= 1'b0;
        end else begin
            r_updatePending <= w_accept;
            r_distanceValid <= r_updatePending && r_primed;
            if (r_updatePending) begin
                r_distance <= r_sum[SUM_W-1:LOG2_DEPTH];
            end
        end
    end

    assign distance       = r_distance;
    assign distance_valid = r_distanceValid;
    assign primed         = r_primed;

`ifdef DISTANCE_SPIKE_REJECT_EN
    localparam int REJ_W = (MAX_REJECTS < 1) ? 1 : $clog2(MAX_REJECTS + 1);
    localparam logic [REJ_W-1:0] REJ_LIMIT = REJ_W'(MAX_REJECTS);
    localparam logic [WIDTH:0]   THRESH    = (WIDTH + 1)'(SPIKE_THRESHOLD);

    logic signed [WIDTH:0] w_diff;
    logic [WIDTH:0]        w_absDiff;
    logic                  w_outlier;
    logic [REJ_W-1:0]      r_rejectCount;
    logic                  r_rejectPending;
    logic                  r_spike;

    assign w_diff    = $signed({1'b0, sample}) - $signed({1'b0, r_distance});
    assign w_absDiff = w_diff[WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_outlier = r_primed && (w_absDiff > THRESH);
    // After MAX_REJECTS consecutive drops the next outlier is let through so a real step is tracked.
    assign w_reject  = w_offered && w_outlier && (r_rejectCount != REJ_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rejectCount   <= '0;
            r_rejectPending <= 1'b0;
            r_spike         <= 1'b0;
        end else begin
            r_rejectPending <= w_reject;
            r_spike         <= r_rejectPending;
            if (w_reject) begin
                r_rejectCount <= r_rejectCount + 1'b1;
            end else if (w_accept) begin
                r_rejectCount <= '0;
            end
        end
    end

    assign spike = r_spike;
`else
    logic w_unusedCfg;

    assign w_reject    = 1'b0;
    assign spike       = 1'b0;
    assign w_unusedCfg = (SPIKE_THRESHOLD != 0) ^ (MAX_REJECTS != 0);
`endif

endmodule

// File: tb/tb_distance_averager.sv
// tb_distance_averager: drives directed and random samples into distance_averager and checks
// every output each cycle against a window-of-samples reference model.
`timescale 1ns/1ps
module tb_distance_averager;
    localparam int WIDTH = 13;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             enable = 1'b0;
    logic             sample_valid = 1'b0;
    logic [WIDTH-1:0] sample = '0;
    logic [WIDTH-1:0] distance;
    logic             distance_valid;
    logic             primed;
    logic             spike;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    distance_averager #(
        .WIDTH(WIDTH),
        .LOG2_DEPTH(4),
        .SPIKE_THRESHOLD(500),
        .MAX_REJECTS(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .sample_valid(sample_valid),
        .sample(sample),
        .distance(distance),
        .distance_valid(distance_valid),
        .primed(primed),
        .spike(spike)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit v, input int s);
        enable       = en;
        sample_valid = v;
        sample       = WIDTH'(s);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Reference model: the window is the last DEPTH accepted samples (zeros before filling);
    // outputs show the floor mean one edge after acceptance.
    int win[$];
    int acceptedN, rejCnt, pendMean, mDist, tot, d;
    bit pend, pendValid, rejPend, mValid, mPrimed, mSpike, acc, rej;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win.delete();
            repeat (DEPTH) win.push_back(0);
            acceptedN = 0;
            rejCnt    = 0;
            pendMean  = 0;
            mDist     = 0;
            pend      = 1'b0;
            pendValid = 1'b0;
            rejPend   = 1'b0;
            mValid    = 1'b0;
            mPrimed   = 1'b0;
            mSpike    = 1'b0;
        end else begin
            acc = 1'b0;
            rej = 1'b0;
            if (enable && sample_valid) begin
                acc = 1'b1;
`ifdef DISTANCE_SPIKE_REJECT_EN
                d = int'(sample) - mDist;
                if (d < 0) d = -d;
                if (mPrimed && d > 500) begin
                    if (rejCnt == 3) begin
                        rejCnt = 0;
                    end else begin
                        rej = 1'b1;
                        acc = 1'b0;
                        rejCnt++;
                    end
                end else begin
                    rejCnt = 0;
                end
`endif
            end
            mValid = 1'b0;
            if (pend) begin
                mDist  = pendMean;
                mValid = pendValid;
            end
            mSpike  = rejPend;
            rejPend = rej;
            pend    = acc;
            if (acc) begin
                win.push_back(int'(sample));
                void'(win.pop_front());
                acceptedN++;
                tot = 0;
                foreach (win[k]) tot += win[k];
                pendMean = tot / DEPTH;
                if (acceptedN >= DEPTH) mPrimed = 1'b1;
                pendValid = mPrimed;
            end
        end
    end

    always @(negedge clk) begin
        if (checking && reset_n) begin
            checkOutput("distance", 32'(distance), 32'(mDist));
            checkOutput("distance_valid", 32'(distance_valid), 32'(mValid));
            checkOutput("primed", 32'(primed), 32'(mPrimed));
            checkOutput("spike", 32'(spike), 32'(mSpike));
        end
    end

    initial begin
        int s;
        #3 reset_n = 1'b0;
        #1;
        checkOutput("rst_distance", 32'(distance), 0);
        checkOutput("rst_valid", 32'(distance_valid), 0);
        checkOutput("rst_primed", 32'(primed), 0);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        checking = 1'b1;

        // Fill with 16 back-to-back samples of 1000.
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1, 1, 1000);
            if (i == 8) begin
                applyStimulus(0, 0, 0);
                checkOutput("fill8_distance", 32'(distance), 500);
            end
            if (i == DEPTH) begin
                checkOutput("fill_primed_at_N", 32'(primed), 1);
                checkOutput("fill_valid_before", 32'(distance_valid), 0);
            end
        end
        applyStimulus(0, 0, 0);
        checkOutput("fill_distance", 32'(distance), 1000);
        checkOutput("fill_valid_pulse", 32'(distance_valid), 1);
        applyStimulus(0, 0, 0);
        checkOutput("fill_valid_single", 32'(distance_valid), 0);

        // Gating: valid samples with enable low are ignored.
        repeat (10) applyStimulus(0, 1, 4000);
        checkOutput("gate_hold", 32'(distance), 1000);
        applyStimulus(1, 1, 1000);
        applyStimulus(0, 0, 0);
        checkOutput("gate_resume", 32'(distance), 1000);

        // Step: one sample of 1800 moves the mean by 800/16.
        applyStimulus(1, 1, 1800);
        applyStimulus(0, 0, 0);
        checkOutput("step_distance", 32'(distance), 1050);
        checkOutput("step_valid", 32'(distance_valid), 1);

        // Asynchronous reset mid-stream, then a partial refill.
        applyStimulus(1, 1, 1200);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_distance", 32'(distance), 0);
        checkOutput("midrst_valid", 32'(distance_valid), 0);
        checkOutput("midrst_primed", 32'(primed), 0);
        checkOutput("midrst_spike", 32'(spike), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (15) applyStimulus(1, 1, 1000);
        applyStimulus(0, 0, 0);
        checkOutput("refill15_primed", 32'(primed), 0);
        checkOutput("refill15_distance", 32'(distance), 937);

        // Pointer wrap with alternating 0/2000.
        doReset();
        for (int i = 0; i < 40; i++) applyStimulus(1, 1, (i % 2 == 0) ? 0 : 2000);
        applyStimulus(0, 0, 0);
        checkOutput("wrap_distance", 32'(distance), 1000);
        checkOutput("wrap_valid", 32'(distance_valid), 1);

        // Outlier burst against a window of 1000.
        doReset();
        repeat (DEPTH) applyStimulus(1, 1, 1000);
        repeat (2) applyStimulus(0, 0, 0);
        repeat (4) applyStimulus(1, 1, 1600);
        repeat (2) applyStimulus(0, 0, 0);
`ifdef DISTANCE_SPIKE_REJECT_EN
        checkOutput("spike_fourth_accepted", 32'(distance), 1037);
`else
        checkOutput("burst_all_accepted", 32'(distance), 1150);
`endif
        applyStimulus(1, 1, 1200);
        repeat (2) applyStimulus(0, 0, 0);
`ifdef DISTANCE_SPIKE_REJECT_EN
        checkOutput("spike_after_1200", 32'(distance), 1050);
`else
        checkOutput("burst_after_1200", 32'(distance), 1162);
`endif

        // Randomized traffic with a reset in the middle.
        doReset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) doReset();
            s = 200 + int'($urandom_range(0, 1600));
            if ($urandom_range(0, 15) == 0) s = int'($urandom_range(0, 8191));
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, s);
        end
        repeat (3) applyStimulus(0, 0, 0);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
